cache_port_arbiter: RTL and testbench

Two-requester front end for the multilevel cache `Controller`. It arbitrates between requester 0 (instruction fetch) and requester 1 (load/store) with round-robin fairness. It drives the selected request onto the Controller's shared address/data/mode inputs and holds them stable while the Controller asserts `Wait`. It returns read data and L1/L2 hit status to the granted requester, and keeps saturating hit/miss statistics plus a miss-service watchdog.

---
 rtl/cache_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_cache_port_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_port_arbiter.sv
// Round-robin front end that lets instruction fetch and load/store share one cache Controller.
// Holds the Controller inputs stable across a transaction and keeps saturating hit/miss statistics.
module cache_port_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [31:0]      addr0,
    input  logic [31:0]      addr1,
    input  logic [7:0]       wdata0,
    input  logic [7:0]       wdata1,
    input  logic             mode0,
    input  logic             mode1,
    output logic             ack0,
    output logic             ack1,
    output logic [7:0]       rsp_data,
    output logic             rsp_hit1,
    output logic             rsp_hit2,
    output logic             rsp_err,
    output logic [31:0]      cache_address,
    output logic [7:0]       cache_data,
    output logic             cache_mode,
    input  logic [7:0]       cache_output_data,
    input  logic             cache_hit1,
    input  logic             cache_hit2,
    input  logic             cache_wait,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] hit1_cnt,
    output logic [CNT_W-1:0] hit2_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] tmo_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam int WCTR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCTR_W-1:0] WCTR_LAST = WCTR_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic              grant_q, grant_d;
    logic [WCTR_W-1:0] wait_ctr_q, wait_ctr_d;
    logic [31:0]       addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              mode_q, mode_d;
    logic [7:0]        rsp_data_q, rsp_data_d;
    logic              rsp_hit1_q, rsp_hit1_d;
    logic              rsp_hit2_q, rsp_hit2_d;
    logic              rsp_err_q, rsp_err_d;
    logic              sel;
    logic [CNT_W-1:0]  hit1_cnt_q, hit2_cnt_q, miss_cnt_q, tmo_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= 1'b0;
            grant_q    <= 1'b0;
            wait_ctr_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            mode_q     <= 1'b0;
            rsp_data_q <= '0;
            rsp_hit1_q <= 1'b0;
            rsp_hit2_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            wait_ctr_q <= wait_ctr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            mode_q     <= mode_d;
            rsp_data_q <= rsp_data_d;
            rsp_hit1_q <= rsp_hit1_d;
            rsp_hit2_q <= rsp_hit2_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        wait_ctr_d = wait_ctr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        mode_d     = mode_q;
        rsp_data_d = rsp_data_q;
        rsp_hit1_d = rsp_hit1_q;
        rsp_hit2_d = rsp_hit2_q;
        rsp_err_d  = rsp_err_q;
        sel        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // With both requesters pending the round-robin pointer breaks the tie.
                    sel        = (req0 && req1) ? rr_ptr_q : req1;
                    grant_d    = sel;
                    addr_d     = sel ? addr1 : addr0;
                    data_d     = sel ? wdata1 : wdata0;
                    mode_d     = sel ? mode1 : mode0;
                    wait_ctr_d = '0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (!cache_wait) begin
                    rsp_data_d = cache_output_data;
                    rsp_hit1_d = cache_hit1;
                    rsp_hit2_d = cache_hit2;
                    rsp_err_d  = 1'b0;
                    state_d    = DONE;
                end else if (wait_ctr_q == WCTR_LAST) begin
                    // Watchdog expiry keeps the previous read data but reports no hit.
                    rsp_hit1_d = 1'b0;
                    rsp_hit2_d = 1'b0;
                    rsp_err_d  = 1'b1;
                    state_d    = DONE;
                end else begin
                    wait_ctr_d = wait_ctr_q + 1'b1;
                end
            end
            DONE: begin
                rr_ptr_d = ~grant_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Exactly one statistic is bumped per completed access, with clear taking priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit1_cnt_q <= '0;
            hit2_cnt_q <= '0;
            miss_cnt_q <= '0;
            tmo_cnt_q  <= '0;
        end else if (stat_clr) begin
            hit1_cnt_q <= '0;
            hit2_cnt_q <= '0;
            miss_cnt_q <= '0;
            tmo_cnt_q  <= '0;
        end else if (state_q == DONE) begin
            if (rsp_err_q) begin
                if (tmo_cnt_q != '1) tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end else if (rsp_hit1_q) begin
                if (hit1_cnt_q != '1) hit1_cnt_q <= hit1_cnt_q + 1'b1;
            end else if (rsp_hit2_q) begin
                if (hit2_cnt_q != '1) hit2_cnt_q <= hit2_cnt_q + 1'b1;
            end else begin
                if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
            end
        end
    end

    assign ack0          = (state_q == DONE) && !grant_q;
    assign ack1          = (state_q == DONE) && grant_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_hit1      = rsp_hit1_q;
    assign rsp_hit2      = rsp_hit2_q;
    assign rsp_err       = rsp_err_q;
    assign cache_address = addr_q;
    assign cache_data    = data_q;
    assign cache_mode    = mode_q;
    assign hit1_cnt      = hit1_cnt_q;
    assign hit2_cnt      = hit2_cnt_q;
    assign miss_cnt      = miss_cnt_q;
    assign tmo_cnt       = tmo_cnt_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Scoreboard bench for cache_port_arbiter: directed transactions push expected responses,
// a negedge monitor pops and compares them whenever an ack appears.
module tb_cache_port_arbiter;

    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 4;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0 = 1'b0, req1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic mode0 = 1'b0, mode1 = 1'b0;
    logic ack0, ack1;
    logic [7:0] rsp_data;
    logic rsp_hit1, rsp_hit2, rsp_err;
    logic [31:0] cache_address;
    logic [7:0] cache_data;
    logic cache_mode;
    logic [7:0] cache_output_data = '0;
    logic cache_hit1 = 1'b0, cache_hit2 = 1'b0, cache_wait = 1'b0;
    logic stat_clr = 1'b0;
    logic [CNT_W-1:0] hit1_cnt, hit2_cnt, miss_cnt, tmo_cnt;

    typedef struct {
        int         who;
        logic [7:0] data;
        logic       h1;
        logic       h2;
        logic       err;
    } exp_t;

    exp_t sbQ[$];
    int total = 0;
    int bad = 0;
    logic [7:0] lastData = '0;
    logic [CNT_W-1:0] eHit1 = '0, eHit2 = '0, eMiss = '0, eTmo = '0;

    cache_port_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .mode0(mode0), .mode1(mode1),
        .ack0(ack0), .ack1(ack1),
        .rsp_data(rsp_data), .rsp_hit1(rsp_hit1), .rsp_hit2(rsp_hit2), .rsp_err(rsp_err),
        .cache_address(cache_address), .cache_data(cache_data), .cache_mode(cache_mode),
        .cache_output_data(cache_output_data), .cache_hit1(cache_hit1),
        .cache_hit2(cache_hit2), .cache_wait(cache_wait),
        .stat_clr(stat_clr),
        .hit1_cnt(hit1_cnt), .hit2_cnt(hit2_cnt), .miss_cnt(miss_cnt), .tmo_cnt(tmo_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v == CMAX) ? v : v + 1'b1;
    endfunction

    task automatic pushExpected(input int who, input logic [7:0] d, input logic h1,
                                input logic h2, input logic err);
        exp_t e;
        e.who  = who;
        e.err  = err;
        e.data = err ? lastData : d;
        e.h1   = err ? 1'b0 : h1;
        e.h2   = err ? 1'b0 : h2;
        lastData = e.data;
        sbQ.push_back(e);
        if (err)       eTmo  = satInc(eTmo);
        else if (h1)   eHit1 = satInc(eHit1);
        else if (h2)   eHit2 = satInc(eHit2);
        else           eMiss = satInc(eMiss);
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, " hit1_cnt"}, 32'(hit1_cnt), 32'(eHit1));
        checkOutput({tag, " hit2_cnt"}, 32'(hit2_cnt), 32'(eHit2));
        checkOutput({tag, " miss_cnt"}, 32'(miss_cnt), 32'(eMiss));
        checkOutput({tag, " tmo_cnt"},  32'(tmo_cnt),  32'(eTmo));
    endtask

    // One transaction: w cycles of Controller wait (or stuck wait), optional stat_clr in DONE.
    task automatic applyStimulus(input string tag, input int who, input logic [31:0] a,
                                 input logic [7:0] wd, input logic md, input int w,
                                 input logic [7:0] d, input logic h1, input logic h2,
                                 input logic stuck, input logic clr);
        int n;
        bit got;
        pushExpected(who, d, h1, h2, stuck);
        @(negedge clk);
        if (who == 0) begin
            addr0 = a; wdata0 = wd; mode0 = md; req0 = 1'b1;
        end else begin
            addr1 = a; wdata1 = wd; mode1 = md; req1 = 1'b1;
        end
        cache_wait = stuck || (w > 0);
        cache_output_data = d;
        cache_hit1 = h1;
        cache_hit2 = h2;
        n = 0;
        got = 0;
        while (!got && n < TIMEOUT + 10) begin
            @(posedge clk);
            n++;
            #1;
            if (!stuck && n == w + 2) cache_wait = 1'b0;
            if (ack0 || ack1) got = 1;
            if (!got && tag == "l2svc") begin
                checkOutput({tag, " addr stable"}, cache_address, a);
                checkOutput({tag, " data stable"}, 32'(cache_data), 32'(wd));
            end
        end
        checkOutput({tag, " ack seen"}, 32'(got), 32'd1);
        checkOutput({tag, " latency"}, n, stuck ? TIMEOUT + 2 : w + 3);
        checkOutput({tag, " cache_address"}, cache_address, a);
        checkOutput({tag, " cache_mode"}, 32'(cache_mode), 32'(md));
        req0 = 1'b0;
        req1 = 1'b0;
        cache_wait = 1'b0;
        if (clr) begin
            stat_clr = 1'b1;
            eHit1 = '0; eHit2 = '0; eMiss = '0; eTmo = '0;
        end
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        checkCounters(tag);
    endtask

    // Scoreboard monitor samples on the falling edge, away from state updates.
    always @(negedge clk) begin
        if (rst_n && (ack0 || ack1)) begin
            exp_t e;
            checkOutput("single ack", 32'(ack0 && ack1), 32'd0);
            if (sbQ.size() == 0) begin
                checkOutput("unexpected ack", 32'd1, 32'd0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("granted requester", ack1 ? 32'd1 : 32'd0, 32'(e.who));
                checkOutput("rsp_data", 32'(rsp_data), 32'(e.data));
                checkOutput("rsp_hit1", 32'(rsp_hit1), 32'(e.h1));
                checkOutput("rsp_hit2", 32'(rsp_hit2), 32'(e.h2));
                checkOutput("rsp_err",  32'(rsp_err),  32'(e.err));
            end
        end
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " ack0"}, 32'(ack0), 32'd0);
        checkOutput({tag, " ack1"}, 32'(ack1), 32'd0);
        checkOutput({tag, " rsp_data"}, 32'(rsp_data), 32'd0);
        checkOutput({tag, " rsp flags"}, 32'({rsp_hit1, rsp_hit2, rsp_err}), 32'd0);
        checkOutput({tag, " cache_address"}, cache_address, 32'd0);
        checkOutput({tag, " cache_data/mode"}, 32'({cache_data, cache_mode}), 32'd0);
        checkCounters(tag);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int k;
        bit got;
        #2;
        checkResetValues("reset");
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("l1hit", 0, 32'h0000_0040, 8'h00, 1'b0, 0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("l2svc", 1, 32'h1000_0000, 8'h3C, 1'b1, 5, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0);

        // Contention: both requesters stay high, grants must alternate starting with 0.
        for (int i = 0; i < 4; i++) pushExpected(i % 2, 8'h5A, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        addr0 = 32'h0000_0100; addr1 = 32'h0000_0200; mode0 = 1'b0; mode1 = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        cache_wait = 1'b0; cache_output_data = 8'h5A; cache_hit1 = 1'b1; cache_hit2 = 1'b0;
        for (k = 0; k < 4; k++) begin
            n = 0;
            got = 0;
            while (!got && n < 20) begin
                @(posedge clk);
                n++;
                #1;
                if (ack0 || ack1) got = 1;
            end
            checkOutput("contend ack seen", 32'(got), 32'd1);
            checkOutput("contend spacing", n, (k == 0) ? 3 : 4);
            checkOutput("contend order", ack1 ? 32'd1 : 32'd0, 32'(k % 2));
        end
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk);
        #1;
        checkCounters("contend");

        applyStimulus("timeout", 0, 32'h0000_0080, 8'h00, 1'b0, 0, 8'hEE, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus("after tmo", 1, 32'h0000_0090, 8'h00, 1'b0, 2, 8'h42, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset during a stalled WAIT aborts without ack.
        @(negedge clk);
        addr0 = 32'h0000_0300; mode0 = 1'b1; wdata0 = 8'h99; req0 = 1'b1; cache_wait = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        eHit1 = '0; eHit2 = '0; eMiss = '0; eTmo = '0;
        lastData = '0;
        checkResetValues("midreset");
        req0 = 1'b0;
        cache_wait = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("post reset", 0, 32'h0000_0300, 8'h99, 1'b1, 0, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 17; i++)
            applyStimulus("miss", i % 2, 32'h2000_0000 + i, 8'h00, 1'b0, 1, 8'(i), 1'b0, 1'b0,
                          1'b0, 1'b0);
        checkOutput("miss saturated", 32'(miss_cnt), 32'd15);
        applyStimulus("clear", 0, 32'h3000_0000, 8'h00, 1'b0, 1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", sbQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
